// File: rtl/cu_sequencer.sv
// cu_sequencer: multi-cycle control sequencer for a LEGv8-style datapath.
// Holds the IR and the 4-bit state register and picks the class decoder's
// control word, k_mux and next state. It stalls on mem_ready and halts on
// an illegal opcode.
// Ports: clock, reset_n (async, active low), instr_in, mem_ready,
//   cw_*/ns_*/km_* (class decoder outputs), IR, state, controlWord,
//   k_mux, halted, instr_count, cycle_count.
// Build option: define CU_PERF_CNT_EN to enable the retire and cycle
//   counters. Without it, both count ports are tied to zero.
module cu_sequencer #(
    parameter int         CUL      = 35,
    parameter logic [1:0] FETCH_CS = 2'b01
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [31:0]  instr_in,
    input  logic         mem_ready,
    input  logic [CUL:0] cw_imm,
    input  logic [CUL:0] cw_reg,
    input  logic [CUL:0] cw_mem,
    input  logic [CUL:0] cw_br,
    input  logic [3:0]   ns_imm,
    input  logic [3:0]   ns_reg,
    input  logic [3:0]   ns_mem,
    input  logic [3:0]   ns_br,
    input  logic [2:0]   km_imm,
    input  logic [2:0]   km_reg,
    input  logic [2:0]   km_mem,
    input  logic [2:0]   km_br,
    output logic [31:0]  IR,
    output logic [3:0]   state,
    output logic [CUL:0] controlWord,
    output logic [2:0]   k_mux,
    output logic         halted,
    output logic [31:0]  instr_count,
    output logic [31:0]  cycle_count
);

    typedef enum logic [3:0] {
        S_FETCH = 4'b0000,
        S_EX0   = 4'b0001,
        S_EX1   = 4'b0010,
        S_EX2   = 4'b0011,
        S_HALT  = 4'b1111
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [31:0]  r_ir;
    logic         r_halted;
    logic         w_ir_load;
    logic         w_is_imm;
    logic         w_is_br;
    logic         w_is_reg;
    logic         w_is_mem;
    logic         w_illegal;
    logic [CUL:0] w_sel_cw;
    logic [3:0]   w_sel_ns;
    logic [2:0]   w_sel_km;
`ifdef CU_PERF_CNT_EN
    logic         w_retire;
    logic [31:0]  r_instr_cnt;
    logic [31:0]  r_cycle_cnt;
`endif

    // These opcode classes do not overlap, so at most one flag is set.
    assign w_is_imm  = (r_ir[28:26] == 3'b100);
    assign w_is_br   = (r_ir[28:26] == 3'b101);
    assign w_is_reg  = (r_ir[27:25] == 3'b101);
    assign w_is_mem  = r_ir[27] & ~r_ir[25];
    assign w_illegal = ~(w_is_imm | w_is_br | w_is_reg | w_is_mem);

    always_comb begin
        w_sel_cw = cw_imm;
        w_sel_ns = ns_imm;
        w_sel_km = km_imm;
        if (w_is_br) begin
            w_sel_cw = cw_br;
            w_sel_ns = ns_br;
            w_sel_km = km_br;
        end else if (w_is_reg) begin
            w_sel_cw = cw_reg;
            w_sel_ns = ns_reg;
            w_sel_km = km_reg;
        end else if (w_is_mem) begin
            w_sel_cw = cw_mem;
            w_sel_ns = ns_mem;
            w_sel_km = km_mem;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_ir_load   = 1'b0;
        controlWord = '0;
        k_mux       = 3'b000;
`ifdef CU_PERF_CNT_EN
        w_retire    = 1'b0;
`endif
        case (r_state)
            S_FETCH: begin
                controlWord[9]     = 1'b1;
                controlWord[13:12] = FETCH_CS;
                controlWord[5]     = 1'b1;
                if (mem_ready) begin
                    w_ir_load = 1'b1;
                    w_next    = S_EX0;
                end
            end
            S_EX0, S_EX1, S_EX2: begin
                if (w_illegal) begin
                    w_next = S_HALT;
                end else begin
                    controlWord = w_sel_cw;
                    k_mux       = w_sel_km;
                    if (w_sel_cw[13:12] != 2'b00 && !mem_ready) begin
                        // While the access is outstanding, suppress any
                        // architectural update. mem_write_en stays asserted.
                        controlWord[15]  = 1'b0;
                        controlWord[8]   = 1'b0;
                        controlWord[1:0] = 2'b00;
                    end else begin
                        case (w_sel_ns)
                            4'b0010: w_next = S_EX1;
                            4'b0011: w_next = S_EX2;
                            default: begin
                                w_next   = S_FETCH;
`ifdef CU_PERF_CNT_EN
                                w_retire = 1'b1;
`endif
                            end
                        endcase
                    end
                end
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_FETCH;
            r_ir     <= '0;
            r_halted <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_ir_load) r_ir <= instr_in;
            if (w_next == S_HALT) r_halted <= 1'b1;
        end
    end

`ifdef CU_PERF_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_instr_cnt <= '0;
            r_cycle_cnt <= '0;
        end else begin
            if (w_retire) r_instr_cnt <= r_instr_cnt + 32'd1;
            if (r_state != S_HALT) r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign instr_count = r_instr_cnt;
    assign cycle_count = r_cycle_cnt;
`else
    assign instr_count = 32'h0;
    assign cycle_count = 32'h0;
`endif

    assign IR     = r_ir;
    assign state  = r_state;
    assign halted = r_halted;

endmodule

// File: tb/tb_cu_sequencer.sv
// Testbench for cu_sequencer: scoreboard of expected per-cycle state,
// control word and k_mux, plus direct checks of IR, halt and counters.
module tb_cu_sequencer;

    localparam logic [35:0] CW_IMM   = 36'h5_1234_8321;
    localparam logic [35:0] CW_REG   = 36'h3_0F0F_0102;
    localparam logic [35:0] CW_BR    = 36'h7_7777_0003;
    localparam logic [35:0] CW_MEM   = 36'h9_8765_A549;
    localparam logic [35:0] CW_MSTL  = 36'h9_8765_2448;
    localparam logic [35:0] CW_FETCH = 36'h0_0000_1220;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] instr_in;
    logic        mem_ready;
    logic [35:0] cw_imm, cw_reg, cw_mem, cw_br;
    logic [3:0]  ns_imm, ns_reg, ns_mem, ns_br;
    logic [2:0]  km_imm, km_reg, km_mem, km_br;
    logic [31:0] IR;
    logic [3:0]  state;
    logic [35:0] controlWord;
    logic [2:0]  k_mux;
    logic        halted;
    logic [31:0] instr_count;
    logic [31:0] cycle_count;

    cu_sequencer dut (
        .clock(clock), .reset_n(reset_n), .instr_in(instr_in),
        .mem_ready(mem_ready),
        .cw_imm(cw_imm), .cw_reg(cw_reg), .cw_mem(cw_mem), .cw_br(cw_br),
        .ns_imm(ns_imm), .ns_reg(ns_reg), .ns_mem(ns_mem), .ns_br(ns_br),
        .km_imm(km_imm), .km_reg(km_reg), .km_mem(km_mem), .km_br(km_br),
        .IR(IR), .state(state), .controlWord(controlWord), .k_mux(k_mux),
        .halted(halted), .instr_count(instr_count),
        .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [35:0] cw;
        logic [2:0]  km;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   n_cyc = 0;
    int   n_ret = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pc(input int n);
`ifdef CU_PERF_CNT_EN
        return n;
`else
        return (n != 0) ? 32'h0 : 32'h0;
`endif
    endfunction

    // Drive one cycle. Sample at the negedge and return at posedge+1.
    task automatic step(input string tag, input logic rdy,
                        input logic [3:0] st, input logic [35:0] cw,
                        input logic [2:0] km);
        exp_t e;
        mem_ready = rdy;
        sb.push_back('{tag, st, cw, km});
        @(negedge clock);
        e = sb.pop_front();
        chk({e.tag, ".state"}, 64'(state), 64'(e.st));
        chk({e.tag, ".cw"}, 64'(controlWord), 64'(e.cw));
        chk({e.tag, ".km"}, 64'(k_mux), 64'(e.km));
        @(posedge clock);
        if (e.st != 4'hF) n_cyc++;
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        mem_ready = 1'b0;
        instr_in = 32'h9100_1441;
        cw_imm = CW_IMM; cw_reg = CW_REG; cw_mem = CW_MEM; cw_br = CW_BR;
        ns_imm = 4'h0; ns_reg = 4'h0; ns_mem = 4'h0; ns_br = 4'h0;
        km_imm = 3'd5; km_reg = 3'd2; km_mem = 3'd6; km_br = 3'd3;
        #12;
        chk("rst.state", 64'(state), 64'h0);
        chk("rst.ir", 64'(IR), 64'h0);
        chk("rst.halted", 64'(halted), 64'h0);
        chk("rst.icnt", 64'(instr_count), 64'h0);
        chk("rst.ccnt", 64'(cycle_count), 64'h0);
        @(posedge clock); #1;
        reset_n = 1'b1;

        // Fetch stall for five cycles
        for (int i = 0; i < 5; i++) step("fstall", 1'b0, 4'h0, CW_FETCH, 3'd0);
        chk("fstall.ir", 64'(IR), 64'h0);
        chk("fstall.ccnt", 64'(cycle_count), 64'(pc(5)));

        // ADDI
        step("addi.f", 1'b1, 4'h0, CW_FETCH, 3'd0);
        chk("addi.ir", 64'(IR), 64'h9100_1441);
        step("addi.ex0", 1'b1, 4'h1, CW_IMM, 3'd5);
        n_ret++;
        chk("addi.end", 64'(state), 64'h0);
        chk("addi.icnt", 64'(instr_count), 64'(pc(n_ret)));

        // MOVK: two EX cycles
        instr_in = 32'hF280_0020;
        step("movk.f", 1'b1, 4'h0, CW_FETCH, 3'd0);
        ns_imm = 4'b0010;
        step("movk.ex0", 1'b1, 4'h1, CW_IMM, 3'd5);
        ns_imm = 4'b0000;
        step("movk.ex1", 1'b1, 4'h2, CW_IMM, 3'd5);
        n_ret++;
        chk("movk.end", 64'(state), 64'h0);
        chk("movk.icnt", 64'(instr_count), 64'(pc(n_ret)));

        // LDUR with a three-cycle memory stall
        instr_in = 32'hF840_0000;
        step("ldur.f", 1'b1, 4'h0, CW_FETCH, 3'd0);
        for (int i = 0; i < 3; i++) step("ldur.stall", 1'b0, 4'h1, CW_MSTL, 3'd6);
        step("ldur.go", 1'b1, 4'h1, CW_MEM, 3'd6);
        n_ret++;
        chk("ldur.end", 64'(state), 64'h0);
        chk("ldur.ir", 64'(IR), 64'hF840_0000);

        // Register class
        instr_in = 32'h8B00_0000;
        step("reg.f", 1'b1, 4'h0, CW_FETCH, 3'd0);
        step("reg.ex0", 1'b1, 4'h1, CW_REG, 3'd2);
        n_ret++;

        // Branch class through EX2
        instr_in = 32'h1400_0000;
        step("br.f", 1'b1, 4'h0, CW_FETCH, 3'd0);
        ns_br = 4'b0011;
        step("br.ex0", 1'b1, 4'h1, CW_BR, 3'd3);
        ns_br = 4'b0000;
        step("br.ex2", 1'b1, 4'h3, CW_BR, 3'd3);
        n_ret++;
        chk("br.icnt", 64'(instr_count), 64'(pc(n_ret)));
        chk("br.ccnt", 64'(cycle_count), 64'(pc(n_cyc)));

        // Async reset in EX1 of MOVK
        instr_in = 32'hF280_0020;
        step("mrst.f", 1'b1, 4'h0, CW_FETCH, 3'd0);
        ns_imm = 4'b0010;
        step("mrst.ex0", 1'b1, 4'h1, CW_IMM, 3'd5);
        chk("mrst.inex1", 64'(state), 64'h2);
        #2 reset_n = 1'b0;
        #1;
        chk("mrst.state", 64'(state), 64'h0);
        chk("mrst.ir", 64'(IR), 64'h0);
        chk("mrst.icnt", 64'(instr_count), 64'h0);
        n_cyc = 0; n_ret = 0;
        ns_imm = 4'b0000;
        @(posedge clock); #1;
        reset_n = 1'b1;
        instr_in = 32'h9100_1441;
        step("post.f", 1'b1, 4'h0, CW_FETCH, 3'd0);
        step("post.ex0", 1'b1, 4'h1, CW_IMM, 3'd5);
        n_ret++;
        chk("post.ir", 64'(IR), 64'h9100_1441);
        chk("post.icnt", 64'(instr_count), 64'(pc(n_ret)));

        // Illegal opcode halts
        instr_in = 32'h0000_0000;
        step("ill.f", 1'b1, 4'h0, CW_FETCH, 3'd0);
        step("ill.ex0", 1'b1, 4'h1, 36'h0, 3'd0);
        chk("ill.halted", 64'(halted), 64'h1);
        for (int i = 0; i < 4; i++)
            step("halt", 1'(i % 2), 4'hF, 36'h0, 3'd0);
        chk("halt.halted", 64'(halted), 64'h1);
        chk("halt.ir", 64'(IR), 64'h0);
        chk("halt.ccnt", 64'(cycle_count), 64'(pc(n_cyc)));
        chk("halt.icnt", 64'(instr_count), 64'(pc(n_ret)));
        #2 reset_n = 1'b0;
        #1;
        chk("hrst.state", 64'(state), 64'h0);
        chk("hrst.halted", 64'(halted), 64'h0);
        chk("hrst.cw", 64'(controlWord), 64'(CW_FETCH));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
- Top-level multi-cycle control sequencer for the LEGv8-style datapath.
- Owns the instruction register and the 4-bit state register that the per-class combinational decoders (immediate, register, memory, branch) consume.
- Classifies each fetched instruction, selects that class decoder's control word, k_mux and next-state, and advances FETCH -> EX0 -> EX1 -> EX2 -> FETCH.
- Stalls on a memory-ready handshake; halts on illegal opcodes.

Parameters:
- CUL, 35, MSB index of the control word (word width is CUL+1 = 36).
- FETCH_CS, 2'b01, mem_cs value driven during FETCH (instruction memory select).

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_in  in  32  instruction read data from memory.
- mem_ready  in  1  memory completed the current access this cycle.
- cw_imm, cw_reg, cw_mem, cw_br  in  CUL+1 each  class decoder control words.
- ns_imm, ns_reg, ns_mem, ns_br  in  4 each  class decoder next-state.
- km_imm, km_reg, km_mem, km_br  in  3 each  class decoder k_mux.
- IR  out  32  instruction register, fed to all decoders.
- state  out  4  current state, fed to all decoders.
- controlWord  out  CUL+1  datapath control word.
- k_mux  out  3  constant/immediate mux select.
- halted  out  1  illegal instruction seen.
- instr_count  out  32  retired instruction count (optional feature).
- cycle_count  out  32  non-halted cycle count (optional feature).

Behaviour:
- Control word field map (LSB first):
  - PC_FS[1:0], PC_sel[2], data_tri_sel[4:3], add_tri_sel[5], size[7:6]
  - status_load[8], IR_load[9], mem_write_en[10], B_Sel[11], mem_cs[13:12]
  - C0[14], w_reg[15], DA[20:16], SB[25:21], SA[30:26], FS[35:31]
- States: FETCH=4'b0000, EX0=4'b0001, EX1=4'b0010, EX2=4'b0011, HALT=4'b1111.
- Reset (asynchronous): state=FETCH, IR=0, halted=0, counters=0. Reset mid-instruction abandons it with no further writes.
- FETCH:
  - Output word has IR_load=1, mem_cs=FETCH_CS, add_tri_sel=1; all other fields 0 (PC_FS=00). k_mux=000.
  - When mem_ready=1: IR<=instr_in and state<=EX0. Otherwise remain in FETCH.
- Class decode from IR, disjoint:
  - imm: IR[28:26]=100
  - br: IR[28:26]=101
  - reg: IR[27:25]=101
  - mem: IR[27]=1 and IR[25]=0
  - none of these: illegal.
- EX states: controlWord, k_mux and NS are taken from the selected class decoder. All outputs are combinational from state and IR; there is no registered output latency.
- Memory stall: in an EX state, if the selected mem_cs!=00 and mem_ready=0, hold the state. While holding, force w_reg=0, status_load=0, mem_write_en held as-is, and PC_FS=00. Release the forced bits on the cycle mem_ready=1.
- Transition at end of an EX cycle (not stalled):
  - NS=0010 -> EX1.
  - NS=0011 -> EX2.
  - Any other NS -> FETCH; the instruction retires.
- Illegal class in EX0: controlWord=0, k_mux=000, next state=HALT, halted=1.
- HALT: controlWord=0, holds until reset_n asserted.
- IR changes only on a FETCH cycle with mem_ready=1.

Optional Feature:
- Macro: CU_PERF_CNT_EN.
- Defined:
  - instr_count increments by 1 on each retire transition (EX->FETCH).
  - cycle_count increments every cycle while state!=HALT.
  - Both are 32-bit and wrap 0xFFFFFFFF->0.
- Undefined: both ports tied to 32'h0; no counter flops.

Test Plan:
- Reset then ADDI 0x91001441 with mem_ready=1 throughout:
  - FETCH (IR_load=1, mem_cs=01) -> EX0 -> FETCH, i.e. 2 cycles.
  - IR=0x91001441; controlWord=cw_imm in EX0; instr_count=1.
- MOVK 0xF2800020 with ns_imm=0010 in EX0 and 0000 in EX1:
  - FETCH -> EX0 -> EX1 -> FETCH.
  - state output shows 0001 then 0010.
- LDUR 0xF8400000 with cw_mem.mem_cs=10 and mem_ready low 3 cycles in EX0:
  - state held at 0001 for 3 cycles, with w_reg=0 and PC_FS=00 during the stall.
  - Advances on the 4th cycle with w_reg=cw_mem[15].
- Fetch stall with mem_ready=0 for 5 cycles: state stays 0000 and IR is unchanged; cycle_count=5.
- Instruction 0x00000000: FETCH -> EX0 -> HALT, halted=1, controlWord=0. Stays halted despite mem_ready toggling; reset_n=0 mid-HALT returns to FETCH asynchronously.
- Async reset asserted in EX1 of MOVK: state=0000 and IR=0 immediately (before the next clock edge); the following fetch proceeds normally.
